// File: rtl/pattern_tx.sv
// pattern_tx: serialises a captured pattern MSB-first, repeated rep+1 times, with a done pulse.
module pattern_tx #(
    parameter int PW = 8,
    parameter int LW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [PW-1:0] pattern,
    input  logic [LW-1:0] len,
    input  logic [3:0]    rep,
    output logic          dout,
    output logic          dout_valid,
    output logic          busy,
    output logic          done
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t        r_state, w_next;
    logic [PW-1:0] r_pat;
    logic [LW-1:0] r_len, r_idx, w_nidx;
    logic [3:0]    r_rep, r_cnt;
    logic          r_dout, w_last;
    assign w_nidx = r_idx - 1'b1;
    assign w_last = (r_idx == '0) && (r_cnt == r_rep);
    always_comb begin
        w_next = r_state;
        if (r_state == IDLE && start) w_next = SHIFT;
        else if (r_state == SHIFT && w_last) w_next = DONE;
        else if (r_state == DONE) w_next = IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else r_state <= w_next;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pat  <= '0;
            r_len  <= '0;
            r_rep  <= '0;
            r_idx  <= '0;
            r_cnt  <= '0;
            r_dout <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_pat  <= pattern;
            r_len  <= len;
            r_rep  <= rep;
            r_idx  <= len;
            r_cnt  <= '0;
            r_dout <= pattern[len];
        end else if (r_state == SHIFT) begin
            // Index wrap restarts the captured pattern with no gap cycle.
            if (w_last) begin
                r_dout <= 1'b0;
            end else if (r_idx == '0) begin
                r_idx  <= r_len;
                r_cnt  <= r_cnt + 1'b1;
                r_dout <= r_pat[r_len];
            end else begin
                r_idx  <= w_nidx;
                r_dout <= r_pat[w_nidx];
            end
        end else begin
            r_dout <= 1'b0;
        end
    end
    assign dout       = r_dout;
    assign dout_valid = (r_state == SHIFT);
    assign busy       = (r_state != IDLE);
    assign done       = (r_state == DONE);
endmodule

// File: tb/tb_pattern_tx.sv
// tb_pattern_tx: drives directed and random jobs and checks against a queue-based bit stream model.
module tb_pattern_tx;
    logic       clk = 1'b0;
    logic       rst, start, dout, dout_valid, busy, done;
    logic [7:0] pattern;
    logic [2:0] len;
    logic [3:0] rep;
    int         total = 0, bad = 0, hits;
    pattern_tx #(.PW(8), .LW(3)) dut (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len), .rep(rep),
        .dout(dout), .dout_valid(dout_valid), .busy(busy), .done(done)
    );
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, dout_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_dout"}, dout, 0);
    endtask
    // Expected stream: rep+1 copies of pattern[len..0], then one done cycle, then idle.
    task automatic run_job(input logic [7:0] p, input int l, input int r, input bit pert,
                           input bit hold, output int nhits);
        bit   q[$];
        logic [2:0] h = 3'b000;
        nhits = 0;
        for (int t = 0; t <= r; t++)
            for (int b = l; b >= 0; b--) q.push_back(p[b]);
        rst = 0; start = 1; pattern = p; len = 3'(l); rep = 4'(r);
        step();
        start = hold;
        foreach (q[i]) begin
            chk("job_valid", dout_valid, 1);
            chk("job_dout", dout, q[i]);
            chk("job_busy", busy, 1);
            chk("job_done", done, 0);
            h = {h[1:0], dout};
            if (i >= 2 && h == 3'b101) nhits++;
            if (pert) begin
                pattern = 8'($urandom);
                len     = 3'($urandom);
                rep     = 4'($urandom);
                start   = hold | 1'($urandom);
            end
            step();
        end
        chk("end_done", done, 1);
        chk("end_valid", dout_valid, 0);
        chk("end_dout", dout, 0);
        chk("end_busy", busy, 1);
        start = hold | (pert & 1'($urandom));
        step();
        chk_idle("post_job");
        start = hold;
    endtask
    initial begin
        rst = 1; start = 0; pattern = 0; len = 0; rep = 0;
        step();
        chk_idle("reset");
        run_job(8'h05, 2, 0, 0, 0, hits);
        step();
        chk_idle("idle_after_05");
        run_job(8'h05, 2, 1, 0, 0, hits);
        chk("detect_101", hits, 2);
        run_job(8'hA5, 7, 0, 1, 0, hits);
        run_job(8'h01, 0, 15, 0, 0, hits);
        run_job(8'hFE, 0, 3, 1, 0, hits);
        run_job(8'hF2, 1, 0, 0, 1, hits);
        run_job(8'h02, 1, 0, 0, 1, hits);
        start = 0;
        step();
        chk_idle("after_hold");
        pattern = 8'h05; len = 3'd2; rep = 4'd0; start = 1;
        step();
        start = 0;
        chk("abort_bit0", dout, 1);
        step();
        chk("abort_bit1", dout, 0);
        chk("abort_valid1", dout_valid, 1);
        rst = 1;
        step();
        chk_idle("abort_reset");
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_idle("abort_quiet");
        end
        rst = 1;
        step();
        chk_idle("reset2");
        for (int n = 0; n < 25; n++)
            run_job(8'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                    1'($urandom), 1'($urandom), hits);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pattern_tx.md
PATTERN_TX -- requirements
Module: pattern_tx

Interface
REQ-001 The block SHALL have parameter PW, default 8, the maximum pattern width in bits.
REQ-002 The block SHALL have parameter LW, default 3, the width of len, equal to clog2(PW).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all logic on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: a request to begin transmission, sampled only in IDLE.
REQ-006 The block SHALL have port pattern, input, PW bits: the bits to transmit, right-aligned.
REQ-007 The block SHALL have port len, input, LW bits: the number of bits to send minus one, so 0 to 7 means 1 to 8 bits.
REQ-008 The block SHALL have port rep, input, 4 bits: the number of transmissions minus one, so 0 to 15 means 1 to 16 back-to-back transmissions.
REQ-009 The block SHALL have port dout, output, 1 bit: the serial data bit, registered.
REQ-010 The block SHALL have port dout_valid, output, 1 bit: high while dout carries a pattern bit.
REQ-011 The block SHALL have port busy, output, 1 bit: high in SHIFT and DONE.
REQ-012 The block SHALL have port done, output, 1 bit: a one-cycle pulse after the final bit.

Function
REQ-013 The block SHALL implement a state machine with three states: IDLE, SHIFT and DONE.
REQ-014 In IDLE with start=1 at edge k, the block SHALL capture pattern, len and rep into internal registers, enter SHIFT, and drive dout=pattern[len] with dout_valid=1 from edge k onward, giving one cycle of latency relative to start.
REQ-015 In SHIFT, the block SHALL present one bit per cycle MSB-first: pattern[len], then pattern[len-1], down to pattern[0].
REQ-016 Bit index wrap: after pattern[0], if transmissions remain, the next cycle SHALL present pattern[len] of the captured pattern with no gap cycle, and dout_valid SHALL stay 1.
REQ-017 A transmission counter SHALL count up to the captured rep.
REQ-018 After bit 0 of the final transmission, the block SHALL enter DONE, where done=1, dout_valid=0, dout=0 and busy=1 for exactly one cycle, then return to IDLE.
REQ-019 Total dout_valid cycles per job SHALL be exactly (len+1)*(rep+1), which is 1 minimum and 128 maximum.
REQ-020 In all cycles where dout_valid=0, dout SHALL be 0.
REQ-021 Changes to pattern, len or rep while busy=1 SHALL have no effect on the job in flight.
REQ-022 start SHALL be ignored in SHIFT and DONE, and a start held high through DONE SHALL begin a new job on the first IDLE cycle.
REQ-023 With len=0, the block SHALL transmit a single bit pattern[0] per transmission.
REQ-024 Pattern bits above index len SHALL be ignored.

Reset
REQ-025 When rst=1 at a rising edge, the block SHALL set state=IDLE, dout=0, dout_valid=0, busy=0 and done=0, and clear all counters and captured registers.
REQ-026 rst SHALL take priority over start and over all in-flight activity; a reset mid-SHIFT SHALL abort the job with no done pulse.
REQ-027 On the first edge after rst deasserts, the block SHALL be able to accept start.

Verification
REQ-028 With pattern=8'h05, len=2, rep=0 and start pulsed for 1 cycle, dout SHALL be 1,0,1 with dout_valid=1 for 3 cycles, followed by done=1 for 1 cycle, then busy=0.
REQ-029 With pattern=8'h05, len=2, rep=1, dout SHALL be 1,0,1,1,0,1 continuously over 6 valid cycles, and a Moore 101 overlapping detector fed from dout SHALL assert y twice.
REQ-030 With pattern=8'hA5, len=7, rep=0, with pattern changed to 8'hFF and start pulsed again on the 3rd valid cycle, dout SHALL be 1,0,1,0,0,1,0,1, with the second start ignored and a single done pulse.
REQ-031 With len=0, rep=15 and pattern[0]=1, the block SHALL produce 16 consecutive valid cycles of dout=1, then done.
REQ-032 With rst asserted on the 2nd valid cycle of a 3-bit job, on the next cycle dout_valid=0, busy=0 and done=0, and no done pulse SHALL follow.
REQ-033 With start held high continuously, len=1, rep=0 and pattern=2'b10, the output SHALL be valid 1,0, then done, then 1 idle cycle, then valid 1,0 again.
